fpga_mem_mem_if_ddr3_emif_0_dmaster_b2p: RTL

Bytes-to-packets decoder for the DDR3 EMIF debug-master path. Consumes the 8-bit Avalon-ST byte stream from the dmaster timing adapter and strips the framing control characters: SOP 0x7A, EOP 0x7B, channel 0x7C, escape 0x7D. Emits a registered Avalon-ST packet stream (data, startofpacket, endofpacket, optional channel) to the downstream packets-to-transactions stage.

---
 rtl/fpga_mem_mem_if_ddr3_emif_0_dmaster_b2p.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fpga_mem_mem_if_ddr3_emif_0_dmaster_b2p.sv
// Bytes-to-packets decoder: strips SOP/EOP/channel/escape framing from a byte stream.
// Optional channel output enabled by defining DMASTER_B2P_CHANNEL_EN.
module fpga_mem_mem_if_ddr3_emif_0_dmaster_b2p (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_startofpacket,
   output logic       out_endofpacket,
`ifdef DMASTER_B2P_CHANNEL_EN
   output logic [7:0] out_channel,
`endif
   input  logic       out_ready
);

   localparam logic [7:0] SOP_CHAR  = 8'h7A;
   localparam logic [7:0] EOP_CHAR  = 8'h7B;
   localparam logic [7:0] CHAN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR  = 8'h7D;
   localparam logic [7:0] ESC_XOR   = 8'h20;

   logic       esc, chan, chan_esc, sop_p, eop_p;
   logic       esc_n, chan_n, chan_esc_n, sop_n, eop_n;
   logic       accept, emit;
   logic [7:0] emit_data;
`ifdef DMASTER_B2P_CHANNEL_EN
   logic [7:0] chan_reg, chan_val;
   logic       chan_ld;
`endif

   // Reset term keeps the upstream moving while the decoder is being flushed.
   assign in_ready = reset || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      esc_n      = esc;
      chan_n     = chan;
      chan_esc_n = chan_esc;
      sop_n      = sop_p;
      eop_n      = eop_p;
      emit       = 1'b0;
      emit_data  = in_data;
`ifdef DMASTER_B2P_CHANNEL_EN
      chan_ld    = 1'b0;
      chan_val   = in_data;
`endif
      if (accept) begin
         if (esc) begin
            emit      = 1'b1;
            emit_data = in_data ^ ESC_XOR;
            esc_n     = 1'b0;
         end else if (chan_esc) begin
`ifdef DMASTER_B2P_CHANNEL_EN
            chan_ld  = 1'b1;
            chan_val = in_data ^ ESC_XOR;
`endif
            chan_esc_n = 1'b0;
         end else if (chan) begin
            // Channel byte is consumed even when there is no channel register.
            if (in_data == ESC_CHAR) chan_esc_n = 1'b1;
`ifdef DMASTER_B2P_CHANNEL_EN
            else chan_ld = 1'b1;
`endif
            chan_n = 1'b0;
         end else begin
            case (in_data)
               SOP_CHAR:  sop_n  = 1'b1;
               EOP_CHAR:  eop_n  = 1'b1;
               CHAN_CHAR: chan_n = 1'b1;
               ESC_CHAR:  esc_n  = 1'b1;
               default:   emit   = 1'b1;
            endcase
         end
         if (emit) begin
            sop_n = 1'b0;
            eop_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         esc               <= 1'b0;
         chan              <= 1'b0;
         chan_esc          <= 1'b0;
         sop_p             <= 1'b0;
         eop_p             <= 1'b0;
         out_valid         <= 1'b0;
         out_data          <= 8'h00;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
`ifdef DMASTER_B2P_CHANNEL_EN
         chan_reg          <= 8'h00;
         out_channel       <= 8'h00;
`endif
      end else begin
         esc      <= esc_n;
         chan     <= chan_n;
         chan_esc <= chan_esc_n;
         sop_p    <= sop_n;
         eop_p    <= eop_n;
`ifdef DMASTER_B2P_CHANNEL_EN
         if (chan_ld) chan_reg <= chan_val;
`endif
         if (emit) begin
            out_valid         <= 1'b1;
            out_data          <= emit_data;
            out_startofpacket <= sop_p;
            out_endofpacket   <= eop_p;
`ifdef DMASTER_B2P_CHANNEL_EN
            out_channel       <= chan_reg;
`endif
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
